// File: rtl/sample_sequencer.sv
// Sample sequencer: latches ADC samples, launches the IIR filter, collects its
// result and hands it to the PWM duty register at the next period boundary.
module sample_sequencer #(
    parameter int unsigned N       = 10,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned OVR_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     adc_data,
    input  logic             adc_valid,
    output logic [N-1:0]     x_n,
    output logic [N-1:0]     x_n1,
    output logic [N-1:0]     y_n1,
    output logic             filt_start,
    input  logic             filt_done,
    input  logic [N-1:0]     filt_y,
    input  logic             pwm_period_end,
    output logic [N-1:0]     duty_val,
    output logic             busy,
    output logic             overrun,
    output logic [OVR_W-1:0] overrun_cnt,
    output logic             timeout_err
);

    localparam int unsigned    CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [N-1:0]   MID  = {1'b1, {(N-1){1'b0}}};
    localparam logic [CW-1:0]  LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT
    } state_t;

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic [N-1:0]  pend;
    logic          pend_v;
    logic          result_take;
    logic          sample_drop;

    // Decoded from the current state, so a strobe on the WAIT exit edge is
    // still treated as arriving while busy.
    always_comb begin
        result_take = 1'b0;
        sample_drop = 1'b0;
        if (state == WAIT && filt_done)
            result_take = 1'b1;
        if (state != IDLE && adc_valid)
            sample_drop = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            filt_start  <= 1'b0;
            wait_cnt    <= '0;
            x_n         <= MID;
            x_n1        <= MID;
            y_n1        <= MID;
            timeout_err <= 1'b0;
        end else begin
            filt_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (adc_valid) begin
                        x_n        <= adc_data;
                        x_n1       <= x_n;
                        state      <= LAUNCH;
                        busy       <= 1'b1;
                        filt_start <= 1'b1;
                    end
                end
                LAUNCH: begin
                    state    <= WAIT;
                    wait_cnt <= '0;
                end
                WAIT: begin
                    if (filt_done) begin
                        y_n1  <= filt_y;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (wait_cnt == LAST) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                        busy        <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overrun     <= 1'b0;
            overrun_cnt <= '0;
        end else if (sample_drop) begin
            overrun <= 1'b1;
            if (overrun_cnt != '1)
                overrun_cnt <= overrun_cnt + 1'b1;
        end
    end

    // A result coinciding with the period boundary bypasses the pending slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend     <= MID;
            pend_v   <= 1'b0;
            duty_val <= MID;
        end else if (result_take) begin
            pend <= filt_y;
            if (pwm_period_end) begin
                duty_val <= filt_y;
                pend_v   <= 1'b0;
            end else begin
                pend_v <= 1'b1;
            end
        end else if (pwm_period_end && pend_v) begin
            duty_val <= pend;
            pend_v   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sample_sequencer.sv
// Directed testbench for sample_sequencer with default parameters.
module tb_sample_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] adc_data = '0;
    logic       adc_valid = 1'b0;
    logic [9:0] x_n, x_n1, y_n1;
    logic       filt_start;
    logic       filt_done = 1'b0;
    logic [9:0] filt_y = '0;
    logic       pwm_period_end = 1'b0;
    logic [9:0] duty_val;
    logic       busy, overrun, timeout_err;
    logic [7:0] overrun_cnt;

    int errors = 0;
    int checks = 0;

    sample_sequencer #(.N(10), .TIMEOUT(64), .OVR_W(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .adc_data       (adc_data),
        .adc_valid      (adc_valid),
        .x_n            (x_n),
        .x_n1           (x_n1),
        .y_n1           (y_n1),
        .filt_start     (filt_start),
        .filt_done      (filt_done),
        .filt_y         (filt_y),
        .pwm_period_end (pwm_period_end),
        .duty_val       (duty_val),
        .busy           (busy),
        .overrun        (overrun),
        .overrun_cnt    (overrun_cnt),
        .timeout_err    (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; adc_valid = 1'b1; adc_data = 10'd99; filt_done = 1'b1; pwm_period_end = 1'b1;
        tick(); tick();
        reset = 1'b0; adc_valid = 1'b0; filt_done = 1'b0; pwm_period_end = 1'b0;
        checks++; if (x_n !== 10'd512) begin errors++; $display("FAIL reset_x_n: got %0d want 512", x_n); end
        checks++; if (x_n1 !== 10'd512) begin errors++; $display("FAIL reset_x_n1: got %0d want 512", x_n1); end
        checks++; if (y_n1 !== 10'd512) begin errors++; $display("FAIL reset_y_n1: got %0d want 512", y_n1); end
        checks++; if (duty_val !== 10'd512) begin errors++; $display("FAIL reset_duty: got %0d want 512", duty_val); end
        checks++; if (busy !== 1'b0 || filt_start !== 1'b0) begin errors++; $display("FAIL reset_busy_start: got %b%b want 00", busy, filt_start); end
        checks++; if (overrun !== 1'b0 || overrun_cnt !== 8'd0 || timeout_err !== 1'b0) begin errors++; $display("FAIL reset_flags: got ovr=%b cnt=%0d to=%b want 0 0 0", overrun, overrun_cnt, timeout_err); end
    endtask

    task automatic test_launch();
        adc_valid = 1'b1; adc_data = 10'd300;
        tick();
        adc_valid = 1'b0;
        checks++; if (x_n !== 10'd300) begin errors++; $display("FAIL launch_x_n: got %0d want 300", x_n); end
        checks++; if (x_n1 !== 10'd512) begin errors++; $display("FAIL launch_x_n1: got %0d want 512", x_n1); end
        checks++; if (filt_start !== 1'b1) begin errors++; $display("FAIL launch_start: got %b want 1", filt_start); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL launch_busy: got %b want 1", busy); end
        tick();
        checks++; if (filt_start !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL launch_single_pulse: got start=%b busy=%b want 0 1", filt_start, busy); end
    endtask

    task automatic test_filter_result();
        tick();
        checks++; if (x_n !== 10'd300 || x_n1 !== 10'd512) begin errors++; $display("FAIL wait_stable_x: got %0d/%0d want 300/512", x_n, x_n1); end
        filt_done = 1'b1; filt_y = 10'd700;
        tick();
        filt_done = 1'b0;
        checks++; if (y_n1 !== 10'd700) begin errors++; $display("FAIL result_y_n1: got %0d want 700", y_n1); end
        checks++; if (duty_val !== 10'd512) begin errors++; $display("FAIL result_duty_held: got %0d want 512", duty_val); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL result_idle: got busy=%b want 0", busy); end
        pwm_period_end = 1'b1;
        tick();
        pwm_period_end = 1'b0;
        checks++; if (duty_val !== 10'd700) begin errors++; $display("FAIL result_duty_load: got %0d want 700", duty_val); end
    endtask

    task automatic test_same_cycle();
        adc_valid = 1'b1; adc_data = 10'd400;
        tick();
        adc_valid = 1'b0;
        tick();
        filt_done = 1'b1; filt_y = 10'd100; pwm_period_end = 1'b1;
        tick();
        filt_done = 1'b0; pwm_period_end = 1'b0;
        checks++; if (duty_val !== 10'd100) begin errors++; $display("FAIL same_duty: got %0d want 100", duty_val); end
        checks++; if (y_n1 !== 10'd100 || x_n !== 10'd400 || x_n1 !== 10'd300) begin errors++; $display("FAIL same_regs: got y=%0d x=%0d x1=%0d want 100 400 300", y_n1, x_n, x_n1); end
        pwm_period_end = 1'b1;
        tick();
        pwm_period_end = 1'b0;
        checks++; if (duty_val !== 10'd100) begin errors++; $display("FAIL same_duty_hold: got %0d want 100", duty_val); end
    endtask

    task automatic test_newest_wins();
        adc_valid = 1'b1; adc_data = 10'd50;
        tick();
        adc_valid = 1'b0;
        tick();
        filt_done = 1'b1; filt_y = 10'd200;
        tick();
        filt_done = 1'b0;
        adc_valid = 1'b1; adc_data = 10'd60;
        tick();
        adc_valid = 1'b0;
        filt_done = 1'b1; filt_y = 10'd777;
        tick();
        filt_done = 1'b0;
        checks++; if (y_n1 !== 10'd200 || busy !== 1'b1) begin errors++; $display("FAIL launch_done_ignored: got y=%0d busy=%b want 200 1", y_n1, busy); end
        filt_done = 1'b1; filt_y = 10'd250;
        tick();
        filt_done = 1'b0;
        checks++; if (duty_val !== 10'd100) begin errors++; $display("FAIL newest_duty_pre: got %0d want 100", duty_val); end
        pwm_period_end = 1'b1;
        tick();
        pwm_period_end = 1'b0;
        checks++; if (duty_val !== 10'd250) begin errors++; $display("FAIL newest_duty: got %0d want 250", duty_val); end
    endtask

    task automatic test_exit_edge();
        adc_valid = 1'b1; adc_data = 10'd123;
        tick();
        adc_valid = 1'b0;
        tick();
        filt_done = 1'b1; filt_y = 10'd333; adc_valid = 1'b1; adc_data = 10'd5;
        tick();
        filt_done = 1'b0; adc_valid = 1'b0;
        checks++; if (x_n !== 10'd123 || x_n1 !== 10'd60) begin errors++; $display("FAIL exit_x: got %0d/%0d want 123/60", x_n, x_n1); end
        checks++; if (overrun !== 1'b1 || overrun_cnt !== 8'd1) begin errors++; $display("FAIL exit_overrun: got %b/%0d want 1/1", overrun, overrun_cnt); end
        checks++; if (y_n1 !== 10'd333 || busy !== 1'b0 || duty_val !== 10'd250) begin errors++; $display("FAIL exit_result: got y=%0d busy=%b duty=%0d want 333 0 250", y_n1, busy, duty_val); end
    endtask

    task automatic test_timeout();
        adc_valid = 1'b1; adc_data = 10'd200;
        tick();
        adc_valid = 1'b0;
        repeat (64) tick();
        checks++; if (busy !== 1'b1 || timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_early: got busy=%b to=%b want 1 0", busy, timeout_err); end
        tick();
        checks++; if (timeout_err !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL timeout_fire: got to=%b busy=%b want 1 0", timeout_err, busy); end
        checks++; if (y_n1 !== 10'd333) begin errors++; $display("FAIL timeout_y_n1: got %0d want 333", y_n1); end
        adc_valid = 1'b1; adc_data = 10'd201;
        tick();
        adc_valid = 1'b0;
        checks++; if (x_n !== 10'd201 || x_n1 !== 10'd200 || filt_start !== 1'b1) begin errors++; $display("FAIL timeout_next_accept: got x=%0d x1=%0d st=%b want 201 200 1", x_n, x_n1, filt_start); end
        pwm_period_end = 1'b1;
        tick();
        pwm_period_end = 1'b0;
        checks++; if (duty_val !== 10'd333) begin errors++; $display("FAIL timeout_pend_kept: got %0d want 333", duty_val); end
    endtask

    task automatic test_overrun();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int r = 0; r < 6; r++) begin
            adc_valid = 1'b1; adc_data = 10'd77;
            tick();
            adc_data = 10'd999;
            repeat (50) tick();
            adc_valid = 1'b0; filt_done = 1'b1; filt_y = 10'd321;
            tick();
            filt_done = 1'b0;
            if (r == 0) begin
                checks++; if (overrun !== 1'b1 || overrun_cnt !== 8'd50) begin errors++; $display("FAIL overrun_first: got %b/%0d want 1/50", overrun, overrun_cnt); end
            end
        end
        checks++; if (overrun_cnt !== 8'd255) begin errors++; $display("FAIL overrun_saturate: got %0d want 255", overrun_cnt); end
        checks++; if (overrun !== 1'b1 || x_n !== 10'd77 || x_n1 !== 10'd77) begin errors++; $display("FAIL overrun_x: got ovr=%b x=%0d x1=%0d want 1 77 77", overrun, x_n, x_n1); end
    endtask

    task automatic test_reset_abort();
        adc_valid = 1'b1; adc_data = 10'd150;
        tick();
        adc_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0; filt_done = 1'b1; filt_y = 10'd999; pwm_period_end = 1'b1;
        tick();
        filt_done = 1'b0; pwm_period_end = 1'b0;
        checks++; if (y_n1 !== 10'd512 || duty_val !== 10'd512) begin errors++; $display("FAIL abort_y_duty: got %0d/%0d want 512/512", y_n1, duty_val); end
        checks++; if (x_n !== 10'd512 || x_n1 !== 10'd512) begin errors++; $display("FAIL abort_x: got %0d/%0d want 512/512", x_n, x_n1); end
        checks++; if (busy !== 1'b0 || filt_start !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b%b want 00", busy, filt_start); end
        checks++; if (overrun !== 1'b0 || overrun_cnt !== 8'd0 || timeout_err !== 1'b0) begin errors++; $display("FAIL abort_flags: got %b/%0d/%b want 0/0/0", overrun, overrun_cnt, timeout_err); end
    endtask

    initial begin
        test_reset();
        test_launch();
        test_filter_result();
        test_same_cycle();
        test_newest_wins();
        test_exit_edge();
        test_timeout();
        test_overrun();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/sample_sequencer.md
SAMPLE_SEQUENCER -- requirements
Module: sample_sequencer

Interface
REQ-001 The block SHALL have parameter N, default 10, meaning sample width in bits for ADC, filter and PWM words.
REQ-002 The block SHALL have parameter TIMEOUT, default 64, meaning the maximum number of WAIT cycles allowed for a filter result.
REQ-003 The block SHALL have parameter OVR_W, default 8, meaning the overrun counter width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port adc_data, input, N bits: unsigned audio sample from the ADC interface.
REQ-007 The block SHALL have port adc_valid, input, 1 bit: one-cycle strobe qualifying adc_data.
REQ-008 The block SHALL have port x_n, output, N bits: current sample x[n] to the filter.
REQ-009 The block SHALL have port x_n1, output, N bits: previous sample x[n-1] to the filter.
REQ-010 The block SHALL have port y_n1, output, N bits: previous filter output y[n-1] fed back to the filter.
REQ-011 The block SHALL have port filt_start, output, 1 bit: one-cycle pulse launching a filter computation.
REQ-012 The block SHALL have port filt_done, input, 1 bit: one-cycle strobe qualifying filt_y.
REQ-013 The block SHALL have port filt_y, input, N bits: filter result y[n].
REQ-014 The block SHALL have port pwm_period_end, input, 1 bit: pulse at PWM counter wrap, the safe duty update point.
REQ-015 The block SHALL have port duty_val, output, N bits: registered duty word to the PWM DAC.
REQ-016 The block SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-017 The block SHALL have port overrun, output, 1 bit: sticky flag, sample dropped.
REQ-018 The block SHALL have port overrun_cnt, output, OVR_W bits: saturating count of dropped samples.
REQ-019 The block SHALL have port timeout_err, output, 1 bit: sticky flag, filter failed to respond.

Function
REQ-020 The FSM SHALL have states IDLE, LAUNCH and WAIT; busy SHALL equal (state != IDLE).
REQ-021 In IDLE with adc_valid=1, on the next edge: x_n<=adc_data, x_n1<=old x_n, state<=LAUNCH.
REQ-022 In LAUNCH, filt_start SHALL be 1 for exactly that cycle (Moore output), and the next state SHALL be WAIT with the wait counter cleared to 0.
REQ-023 In WAIT with filt_done=1: y_n1<=filt_y, pend<=filt_y, pend_v<=1, state<=IDLE.
REQ-024 In WAIT without filt_done, the counter SHALL increment; when the counter reaches TIMEOUT-1 without filt_done, the next edge SHALL set timeout_err, return to IDLE, and leave y_n1 and pend unchanged.
REQ-025 filt_done in IDLE or LAUNCH SHALL be ignored.
REQ-026 x_n, x_n1 and y_n1 SHALL remain stable from LAUNCH until WAIT exits.
REQ-027 adc_valid while busy=1 SHALL drop the sample: x registers unchanged, overrun<=1, and overrun_cnt increments, saturating at 2^OVR_W-1.
REQ-028 adc_valid on the same edge that WAIT exits to IDLE SHALL be dropped, because the state is still WAIT.
REQ-029 On pwm_period_end with pend_v=1: duty_val<=pend, pend_v<=0.
REQ-030 On pwm_period_end with pend_v=0, duty_val SHALL hold.
REQ-031 If filt_done (in WAIT) and pwm_period_end occur in the same cycle, duty_val SHALL load filt_y directly and pend_v SHALL remain 0.
REQ-032 A second result arriving before pwm_period_end SHALL overwrite pend, so only the newest result reaches duty_val.
REQ-033 All arithmetic SHALL be unsigned N-bit; the block performs no scaling or truncation.
REQ-034 Latency SHALL be: adc_valid at cycle t gives filt_start at t+1, and filt_done at cycle d gives y_n1 updated at d+1.

Reset
REQ-035 While reset=1 at a clock edge: state<=IDLE; x_n, x_n1, y_n1, pend and duty_val <= 2^(N-1) (midscale, 512 for N=10); pend_v, filt_start, busy, overrun, timeout_err <= 0; overrun_cnt <= 0.
REQ-036 Reset asserted mid-operation (LAUNCH or WAIT) SHALL abort the computation, and a filt_done arriving in the cycle after reset SHALL be ignored.
REQ-037 Reset SHALL take priority over every other input in the same cycle.

Verification
REQ-038 Scenario: reset, then adc_valid with adc_data=300 -> x_n=300 and x_n1=512 one cycle later, filt_start pulses once in the same cycle, and busy=1.
REQ-039 Scenario: filt_done with filt_y=700 three cycles after filt_start, no pwm_period_end -> y_n1=700 and duty_val stays 512; then pwm_period_end -> duty_val=700 on the next edge.
REQ-040 Scenario: filt_done with filt_y=100 and pwm_period_end in the same cycle -> duty_val=100, and a later pwm_period_end holds 100.
REQ-041 Scenario: 300 adc_valid pulses, each while busy -> overrun=1, overrun_cnt=255 (saturated), and x_n unchanged.
REQ-042 Scenario: filt_start with filt_done never asserted -> after 64 WAIT cycles, timeout_err=1, state IDLE, y_n1 unchanged; the next adc_valid is accepted.
REQ-043 Scenario: reset pulsed during WAIT, then filt_done -> all outputs at reset values, and y_n1 stays 512.
